// File: rtl/mem_stage_ld_if.sv
// Bus bundle for mem_stage_ld: EX inputs, pipeline stall vector, data SRAM
// read return, and the WB / ID-forwarding outputs.
interface mem_stage_ld_if #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RA_W    = 5,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;

    logic [PC_W-1:0]    ex_pc;
    logic               ex_load;
    logic [2:0]         ex_load_op;
    logic               ex_rf_we;
    logic [RA_W-1:0]    ex_rf_waddr;
    logic [DATA_W-1:0]  ex_result;

    logic [DATA_W-1:0]  data_sram_rdata;
    logic               data_sram_data_ok;

    logic               stallreq_mem;

    logic [PC_W-1:0]    wb_pc;
    logic               wb_rf_we;
    logic [RA_W-1:0]    wb_rf_waddr;
    logic [DATA_W-1:0]  wb_rf_wdata;

    logic               fwd_rf_we;
    logic [RA_W-1:0]    fwd_rf_waddr;
    logic [DATA_W-1:0]  fwd_rf_wdata;

    logic               mem_adel;

    // The stage itself
    modport slave (
        input  stall,
        input  ex_pc, ex_load, ex_load_op, ex_rf_we, ex_rf_waddr, ex_result,
        input  data_sram_rdata, data_sram_data_ok,
        output stallreq_mem,
        output wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
        output fwd_rf_we, fwd_rf_waddr, fwd_rf_wdata,
        output mem_adel
    );

    // Surrounding pipeline / environment
    modport master (
        output stall,
        output ex_pc, ex_load, ex_load_op, ex_rf_we, ex_rf_waddr, ex_result,
        output data_sram_rdata, data_sram_data_ok,
        input  stallreq_mem,
        input  wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
        input  fwd_rf_we, fwd_rf_waddr, fwd_rf_wdata,
        input  mem_adel
    );
endinterface

// File: rtl/mem_stage_ld.sv
// MEM stage between EX and WB: variable-latency loads with byte/half extraction.
// Define MEM_ALIGN_CHECK_EN to flag misaligned lw/lh/lhu on mem_adel.
module mem_stage_ld #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int RA_W    = 5,
    parameter int STALL_W = 6
) (
    input logic           clk,
    input logic           rst,
    mem_stage_ld_if.slave bus
);

    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state, state_nxt;

    logic              r_load;
    logic [2:0]        r_load_op;
    logic              r_we;
    logic [RA_W-1:0]   r_waddr;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_result;
    logic              r_adel;

    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] ext_live;

    logic              take_bubble;
    logic              take_ex;
    logic              ex_adel;
    logic              ld_start;

    logic              stallreq;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    logic              unused_stall;

    // Little-endian sub-word select from the low word, then sign/zero extend
    function automatic logic [DATA_W-1:0] extract(
        input logic [2:0]        op,
        input logic [1:0]        off,
        input logic [DATA_W-1:0] raw
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] res;
        b = raw[{off, 3'b000} +: 8];
        h = raw[{off[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   res = {{(DATA_W-8){b[7]}}, b};
            OP_LBU:  res = {{(DATA_W-8){1'b0}}, b};
            OP_LH:   res = {{(DATA_W-16){h[15]}}, h};
            OP_LHU:  res = {{(DATA_W-16){1'b0}}, h};
            default: res = raw;
        endcase
        return res;
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        logic bad;
        case (op)
            OP_LB, OP_LBU: bad = 1'b0;
            OP_LH, OP_LHU: bad = a[0];
            default:       bad = (a != 2'b00);
        endcase
        return bad;
    endfunction

    assign ex_adel = bus.ex_load && misaligned(bus.ex_load_op, bus.ex_result[1:0]);
`else
    assign ex_adel = 1'b0;
`endif

    assign take_bubble  = bus.stall[3] && !bus.stall[4];
    assign take_ex      = !bus.stall[3];
    assign ld_start     = take_ex && bus.ex_load && !ex_adel;
    assign unused_stall = ^bus.stall;

    // EX/MEM register: reset > bubble > load > hold
    always_ff @(posedge clk) begin
        if (rst || take_bubble) begin
            r_load    <= 1'b0;
            r_load_op <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_pc      <= '0;
            r_result  <= '0;
        end else if (take_ex) begin
            r_load    <= bus.ex_load;
            r_load_op <= bus.ex_load_op;
            r_we      <= bus.ex_rf_we;
            r_waddr   <= bus.ex_rf_waddr;
            r_pc      <= bus.ex_pc;
            r_result  <= bus.ex_result;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst || take_bubble) begin
            r_adel <= 1'b0;
        end else if (take_ex) begin
            r_adel <= ex_adel;
        end
    end
`else
    assign r_adel = 1'b0;
`endif

    assign ext_live = extract(r_load_op, r_result[1:0], bus.data_sram_rdata);

    // Extended data is kept so WB sees a stable value while the stage is held
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_data <= '0;
        end else if (state == S_WAIT && bus.data_sram_data_ok) begin
            cap_data <= ext_live;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Whatever the input register takes in decides the state; otherwise only WAIT moves
    always_comb begin
        state_nxt = state;
        if (take_bubble) begin
            state_nxt = S_IDLE;
        end else if (take_ex) begin
            state_nxt = ld_start ? S_WAIT : S_IDLE;
        end else if (state == S_WAIT && bus.data_sram_data_ok) begin
            state_nxt = S_HOLD;
        end
    end

    always_comb begin
        stallreq = 1'b0;
        rf_we    = r_we && !r_adel;
        rf_wdata = r_result;
        if (state == S_WAIT && !bus.data_sram_data_ok) begin
            stallreq = 1'b1;
            rf_we    = 1'b0;
        end
        if (r_load) begin
            rf_wdata = (state == S_WAIT) ? ext_live : cap_data;
        end
    end

    assign bus.stallreq_mem = stallreq;

    assign bus.wb_pc        = r_pc;
    assign bus.wb_rf_we     = rf_we;
    assign bus.wb_rf_waddr  = r_waddr;
    assign bus.wb_rf_wdata  = rf_wdata;

    assign bus.fwd_rf_we    = rf_we;
    assign bus.fwd_rf_waddr = r_waddr;
    assign bus.fwd_rf_wdata = rf_wdata;

    assign bus.mem_adel     = r_adel;

endmodule

// File: tb/tb_mem_stage_ld.sv
// Self-checking bench for mem_stage_ld: directed cases then randomized
// instruction/latency/stall mix, writes checked through a scoreboard queue.
module tb_mem_stage_ld;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int AW = 5;
    localparam int SW = 6;

    localparam logic [5:0] RUN   = 6'b000000;
    localparam logic [5:0] HOLDS = 6'b011111;
    localparam logic [5:0] BUB   = 6'b001111;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_stage_ld_if #(.DATA_W(DW), .PC_W(PW), .RA_W(AW), .STALL_W(SW)) bus ();

    mem_stage_ld #(.DATA_W(DW), .PC_W(PW), .RA_W(AW), .STALL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference for load data: plain shift/mask arithmetic on the returned word
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (addr % 4))) & 32'd255;
        h = (rd >> (16 * ((addr / 2) % 2))) & 32'd65535;
        case (op)
            3'd1:    return (b < 128) ? b : b + 32'hFFFF_FF00;
            3'd2:    return b;
            3'd3:    return (h < 32768) ? h : h + 32'hFFFF_0000;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic bit ref_misaligned(input bit ld, input logic [2:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        if (!ld) return 1'b0;
        if (op == 3'd1 || op == 3'd2) return 1'b0;
        if (op == 3'd3 || op == 3'd4) return (addr % 2) != 0;
        return (addr % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // A write is consumed by WB whenever it is presented while WB is not stalled
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.wb_rf_we === 1'b1 && bus.stall[4] === 1'b0) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got waddr %0d wdata %h, required no write (t=%0t)",
                         bus.wb_rf_waddr, bus.wb_rf_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_pc",        bus.wb_pc,               mon_e.pc);
                chk("wb_rf_waddr",  32'(bus.wb_rf_waddr),    32'(mon_e.wa));
                chk("wb_rf_wdata",  bus.wb_rf_wdata,         mon_e.wd);
                chk("fwd_rf_we",    32'(bus.fwd_rf_we),      32'd1);
                chk("fwd_rf_waddr", 32'(bus.fwd_rf_waddr),   32'(mon_e.wa));
                chk("fwd_rf_wdata", bus.fwd_rf_wdata,        mon_e.wd);
                chk("mem_adel_wr",  32'(bus.mem_adel),       32'd0);
            end
        end
    end

    task automatic drive_nop();
        bus.ex_pc       = '0;
        bus.ex_load     = 1'b0;
        bus.ex_load_op  = '0;
        bus.ex_rf_we    = 1'b0;
        bus.ex_rf_waddr = '0;
        bus.ex_result   = '0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_pc"},       bus.wb_pc,                 32'd0);
        chk({name, "_we"},       32'(bus.wb_rf_we),         32'd0);
        chk({name, "_waddr"},    32'(bus.wb_rf_waddr),      32'd0);
        chk({name, "_wdata"},    bus.wb_rf_wdata,           32'd0);
        chk({name, "_fwd_we"},   32'(bus.fwd_rf_we),        32'd0);
        chk({name, "_fwd_wa"},   32'(bus.fwd_rf_waddr),     32'd0);
        chk({name, "_fwd_wd"},   bus.fwd_rf_wdata,          32'd0);
        chk({name, "_stallreq"}, 32'(bus.stallreq_mem),     32'd0);
        chk({name, "_adel"},     32'(bus.mem_adel),         32'd0);
    endtask

    // Called and returns at posedge+1. dly = cycles before data_ok, hold = held cycles.
    task automatic issue(input bit ld, input logic [2:0] op, input bit we, input logic [4:0] wa,
                         input logic [31:0] res, input logic [31:0] rd,
                         input int unsigned dly, input int unsigned hold, input bit bub_in);
        logic [31:0] pc;
        logic [31:0] exp_wd;
        bit          mis;
        bit          bub;
        pc     = $urandom;
        mis    = ref_misaligned(ld, op, res);
        bub    = bub_in && (hold == 0) && !mis;
        exp_wd = ld ? ref_load(op, res, rd) : res;

        bus.stall             = RUN;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = $urandom;
        bus.ex_pc             = pc;
        bus.ex_load           = ld;
        bus.ex_load_op        = op;
        bus.ex_rf_we          = we;
        bus.ex_rf_waddr       = wa;
        bus.ex_result         = res;
        if (we && !mis) exp_q.push_back('{pc: pc, wa: wa, wd: exp_wd});
        @(posedge clk); #1;
        drive_nop();

        if (mis) begin
            @(negedge clk);
            chk("adel_flag",     32'(bus.mem_adel),     32'd1);
            chk("adel_we",       32'(bus.wb_rf_we),     32'd0);
            chk("adel_stallreq", 32'(bus.stallreq_mem), 32'd0);
            @(posedge clk); #1;
        end else begin
            if (ld) begin
                for (int unsigned i = 0; i < dly; i++) begin
                    bus.stall           = HOLDS;
                    bus.data_sram_rdata = $urandom;
                    @(negedge clk);
                    chk("wait_stallreq", 32'(bus.stallreq_mem), 32'd1);
                    chk("wait_we",       32'(bus.wb_rf_we),     32'd0);
                    chk("wait_fwd_we",   32'(bus.fwd_rf_we),    32'd0);
                    @(posedge clk); #1;
                end
                bus.data_sram_data_ok = 1'b1;
                bus.data_sram_rdata   = rd;
                bus.stall             = (hold != 0) ? HOLDS : (bub ? BUB : RUN);
                @(negedge clk);
                chk("data_stallreq", 32'(bus.stallreq_mem), 32'd0);
                chk("data_wdata",    bus.wb_rf_wdata,       exp_wd);
                @(posedge clk); #1;
                bus.data_sram_data_ok = 1'b0;
            end
            for (int unsigned h = 0; h < hold; h++) begin
                bus.stall             = HOLDS;
                bus.data_sram_rdata   = $urandom;
                bus.data_sram_data_ok = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("hold_wdata",    bus.wb_rf_wdata,       exp_wd);
                chk("hold_we",       32'(bus.wb_rf_we),     32'(we));
                chk("hold_stallreq", 32'(bus.stallreq_mem), 32'd0);
                @(posedge clk); #1;
            end
            bus.data_sram_data_ok = 1'b0;
            if (bub) begin
                if (!ld) begin
                    bus.stall = BUB;
                    @(posedge clk); #1;
                end
                bus.stall = RUN;
                @(negedge clk);
                chk_zero("bubble");
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        bit          ld;

        rst                   = 1'b1;
        bus.stall             = RUN;
        bus.data_sram_rdata   = '0;
        bus.data_sram_data_ok = 1'b0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;

        issue(1'b0, 3'd0, 1'b1, 5'd5,  32'h1234_5678, 32'h0,         0, 0, 1'b0);
        issue(1'b1, 3'd1, 1'b1, 5'd7,  32'h0000_1003, 32'h80FF_1234, 0, 0, 1'b0);
        issue(1'b1, 3'd2, 1'b1, 5'd8,  32'h0000_1003, 32'h80FF_1234, 0, 0, 1'b0);
        issue(1'b1, 3'd4, 1'b1, 5'd6,  32'h0000_1002, 32'h80FF_1234, 0, 0, 1'b0);
        issue(1'b1, 3'd0, 1'b1, 5'd9,  32'h0000_1000, 32'hDEAD_BEEF, 3, 0, 1'b0);
        issue(1'b1, 3'd3, 1'b1, 5'd10, 32'h0000_0002, 32'h8001_5A5A, 0, 2, 1'b0);
        issue(1'b0, 3'd0, 1'b1, 5'd3,  32'hCAFE_F00D, 32'h0,         0, 0, 1'b1);

        // Reset while a load is outstanding; the late data must not write
        bus.stall       = RUN;
        bus.ex_pc       = 32'h0000_4000;
        bus.ex_load     = 1'b1;
        bus.ex_load_op  = 3'd0;
        bus.ex_rf_we    = 1'b1;
        bus.ex_rf_waddr = 5'd12;
        bus.ex_result   = 32'h0000_3000;
        @(posedge clk); #1;
        drive_nop();
        bus.stall = HOLDS;
        @(negedge clk);
        chk("rstwait_stallreq", 32'(bus.stallreq_mem), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst                   = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h5555_AAAA;
        @(negedge clk);
        chk_zero("rst_mid_wait");
        @(posedge clk); #1;
        bus.data_sram_data_ok = 1'b0;
        bus.stall             = RUN;
        @(negedge clk);
        chk_zero("after_rst");
        @(posedge clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
        issue(1'b1, 3'd0, 1'b1, 5'd4, 32'h0000_1002, 32'h1111_2222, 1, 0, 1'b0);
        issue(1'b1, 3'd3, 1'b1, 5'd4, 32'h0000_1002, 32'h9876_1111, 1, 0, 1'b0);
`endif

        for (int n = 0; n < 300; n++) begin
            ld   = ($urandom_range(0, 1) == 1);
            op   = 3'($urandom_range(0, 7));
            addr = $urandom;
            issue(ld, op, ($urandom_range(0, 9) != 0), 5'($urandom), addr, $urandom,
                  $urandom_range(0, 4), $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
        end

        drive_nop();
        bus.stall = RUN;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage_ld.md
Name: mem_stage_ld

Overview:
Parametrised memory-access pipeline stage that sits between EX and WB and generalises the fixed 32-bit MEM stage. It latches EX results under the standard stall/bubble rule and forwards them to ID and WB. It also supports variable-latency data SRAM reads through a data_ok handshake, and performs byte/halfword load extraction with sign or zero extension. While a load is outstanding it raises a stall request to the pipeline controller.

Parameters:
DATA_W, 32, data path and register width (multiple of 16)
PC_W, 32, program counter width
RA_W, 5, register-file address width
STALL_W, 6, stall bus width; bit 3 = MEM stage, bit 4 = WB stage

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  STALL_W  pipeline stall vector, 1 = Stop
ex_pc  in  PC_W  PC of the instruction leaving EX
ex_load  in  1  instruction is a load
ex_load_op  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others treated as lw
ex_rf_we  in  1  register write enable
ex_rf_waddr  in  RA_W  destination register
ex_result  in  DATA_W  ALU result; byte address for loads
data_sram_rdata  in  DATA_W  read data from data SRAM
data_sram_data_ok  in  1  rdata valid this cycle
stallreq_mem  out  1  request pipeline stall; load data not yet returned
wb_pc  out  PC_W  PC to WB
wb_rf_we  out  1  write enable to WB
wb_rf_waddr  out  RA_W  destination to WB
wb_rf_wdata  out  DATA_W  write data to WB
fwd_rf_we  out  1  forwarding write enable to ID
fwd_rf_waddr  out  RA_W  forwarding destination to ID
fwd_rf_wdata  out  DATA_W  forwarding data to ID
mem_adel  out  1  load address error (optional feature only)

Behaviour:
- Reset: one clock, synchronous, active-high. On rst, the input register, the capture register and the FSM clear to zero / IDLE. All outputs read 0 in the cycle after the reset edge.
- Input register, priority order: rst > (stall[3]=Stop and stall[4]=NoStop → load all-zero bubble) > (stall[3]=NoStop → load EX fields) > hold.
- Non-load: outputs are purely combinational from the register. wdata = ex_result. Latency is one cycle from EX.
- Load extraction (little-endian): off = addr[1:0] of latched result.
  - lb/lbu: byte off, sign-/zero-extended to DATA_W.
  - lh/lhu: half addr[1], sign-/zero-extended.
  - lw: low DATA_W bits unchanged.
- FSM states:
  - IDLE: register holds a non-load, a bubble, or a completed load.
  - WAIT: load latched, data not yet returned.
  - HOLD: data captured, stage still held.
- FSM transitions:
  - On a cycle that latches a load, the next state is WAIT.
  - WAIT, data_ok=0: stallreq_mem=1; wb_rf_we=0 and fwd_rf_we=0.
  - WAIT, data_ok=1: stallreq_mem=0. Extended live rdata drives wdata and is captured. Next state is IDLE if stall[3]=NoStop, else HOLD.
  - HOLD: wdata comes from the capture register. Go to IDLE when stall[3]=NoStop.
  - A new load latched from HOLD or IDLE goes directly to WAIT.
- Data valid same cycle as latch: a load whose data_ok arrives in the first cycle after latch never asserts stallreq_mem.
- stallreq_mem depends only on FSM state and data_ok, with no combinational path from stall.
- data_ok received in IDLE or HOLD is ignored.
- Reset mid-WAIT: FSM returns to IDLE; a late data_ok is ignored.
- fwd_* always equals wb_* (same cycle, same gating).

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - mem_adel=1 when lh/lhu has addr[0]=1, or lw has addr[1:0]≠0.
  - In that case wb_rf_we=0 and fwd_rf_we=0, the FSM does not enter WAIT, and stallreq_mem=0.
  - mem_adel is registered with the instruction and clears on bubble or reset.
- Undefined:
  - mem_adel is tied to 0.
  - lw ignores addr[1:0], and lh/lhu ignore addr[0].

Test Plan:
1. ALU op: ex_result=0x12345678, we=1, waddr=5, no stall → next cycle wb_rf_wdata=0x12345678, wb_rf_we=1, waddr=5, fwd_* identical.
2. lb, addr=0x1003, rdata=0x80FF1234, data_ok in first cycle → wdata=0xFFFFFF80, stallreq_mem never 1. Repeat with lbu → 0x00000080. Repeat with lhu addr=0x1002 → 0x000080FF.
3. lw with data_ok delayed 3 cycles, rdata=0xDEADBEEF → stallreq_mem=1 for exactly 3 cycles, wb_rf_we=0 throughout. On the 4th cycle wdata=0xDEADBEEF and stallreq_mem=0.
4. lh addr=0x2, rdata=0x8001xxxx, data_ok together with stall[3]=1, stall[4]=1 for 2 more cycles while rdata changes → wdata holds 0xFFFF8001 (HOLD); IDLE after release.
5. stall[3]=1, stall[4]=0 → next cycle all wb_*/fwd_* are 0 (bubble). rst asserted during WAIT → IDLE, stallreq_mem=0, and a subsequent data_ok produces no write.
6. (MEM_ALIGN_CHECK_EN) lw addr=0x1002 → mem_adel=1, wb_rf_we=0, stallreq_mem=0. lh addr=0x1002 → mem_adel=0.
